// File: rtl/cp0_pkg.sv
// Shared CP0 register numbers, bit positions and exception codes for the
// MIPS coprocessor-0 slice.
package cp0_pkg;

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_SR      = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;

    localparam int SR_IE        = 0;
    localparam int SR_EXL       = 1;
    localparam int CAUSE_BD     = 31;
    localparam int IM_LO        = 8;
    localparam int IM_HI        = 15;
    localparam int EXC_LO       = 2;
    localparam int EXC_HI       = 6;
    localparam int IP_HWINT_LO  = 10;
    localparam int IP_TIMER     = 15;

    typedef enum logic [4:0] {
        EXC_INT     = 5'd0,
        EXC_ADEL    = 5'd4,
        EXC_ADES    = 5'd5,
        EXC_SYSCALL = 5'd8,
        EXC_RI      = 5'd10,
        EXC_OV      = 5'd12
    } exc_code_e;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer for CP0; raises timer_pend the edge after Count
// reaches Compare and clears it on any write to Compare.
module cp0_timer
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_pend
);

    logic wr_count;
    logic wr_compare;

    assign wr_count   = we && (addr == REG_COUNT);
    assign wr_compare = we && (addr == REG_COMPARE);

    // Compare resets to all-ones so a freshly reset Count cannot match it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count      <= '0;
            compare    <= 32'hFFFF_FFFF;
            timer_pend <= 1'b0;
        end else begin
            if (wr_count)
                count <= wdata;
            else
                count <= count + 32'd1;

            if (wr_compare) begin
                compare    <= wdata;
                timer_pend <= 1'b0;
            end else if (count == compare) begin
                timer_pend <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_irq_ctrl.sv
// Coprocessor-0 beside the M stage: SR/Cause/EPC/PRId plus optional timer,
// deciding each cycle whether the pipeline must redirect to the handler.
module cp0_irq_ctrl
    import cp0_pkg::*;
#(
    parameter int          NUM_HWINT = 5,
    parameter bit          TIMER_EN  = 1'b1,
    parameter logic [31:0] PRID      = 32'h0000_0001
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [4:0]           addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    input  logic [31:0]          vpc,
    input  logic                 bd_in,
    input  logic [4:0]           exc_code_in,
    input  logic [NUM_HWINT-1:0] hwint,
    input  logic                 eret,
    output logic                 req,
    output logic [31:0]          epc_out
);

    logic [7:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [4:0]  exc_code;
    logic [4:0]  ip_hw;
    logic [31:0] epc;
    logic [31:0] count;
    logic [31:0] compare;
    logic        timer_pend;
    logic [4:0]  hw_ext;
    logic [7:0]  ip;
    logic        int_pend;
    logic        mtc0_ok;

    // A flushed mtc0 (same cycle as req) must not reach the timer either.
    assign mtc0_ok = we && !req;

    generate
        if (TIMER_EN) begin : g_timer
            cp0_timer u_timer (
                .clk        (clk),
                .reset      (reset),
                .we         (mtc0_ok),
                .addr       (addr),
                .wdata      (wdata),
                .count      (count),
                .compare    (compare),
                .timer_pend (timer_pend)
            );
        end else begin : g_no_timer
            assign count      = '0;
            assign compare    = '0;
            assign timer_pend = 1'b0;
        end
    endgenerate

    always_comb begin
        hw_ext                  = '0;
        hw_ext[NUM_HWINT-1:0]   = hwint;
    end

    assign ip       = {timer_pend, ip_hw, 2'b00};
    assign int_pend = ie && |(ip & im);
    assign req      = !exl && (int_pend || (exc_code_in != 5'd0));
    assign epc_out  = epc;

    // Per-bit priority: exception entry, then eret, then a surviving mtc0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            exc_code <= '0;
            ip_hw    <= '0;
            epc      <= '0;
        end else begin
            ip_hw <= hw_ext;
            if (req) begin
                exl      <= 1'b1;
                bd       <= bd_in;
                exc_code <= int_pend ? EXC_INT : exc_code_in;
                epc      <= bd_in ? vpc - 32'd4 : vpc;
            end else begin
                if (eret)
                    exl <= 1'b0;
                else if (we && addr == REG_SR)
                    exl <= wdata[SR_EXL];
                if (we && addr == REG_SR) begin
                    im <= wdata[IM_HI:IM_LO];
                    ie <= wdata[SR_IE];
                end
                if (we && addr == REG_EPC)
                    epc <= wdata;
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            REG_COUNT:   rdata = count;
            REG_COMPARE: rdata = compare;
            REG_SR:      rdata = {16'b0, im, 6'b0, exl, ie};
            REG_CAUSE:   rdata = {bd, 15'b0, ip, 1'b0, exc_code, 2'b0};
            REG_EPC:     rdata = epc;
            REG_PRID:    rdata = PRID;
            default:     rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Scoreboard bench for cp0_irq_ctrl: expected values are queued as stimulus
// is applied and popped when the matching DUT output is sampled.
module tb_cp0_irq_ctrl;
    import cp0_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [4:0]  hwint;
    logic        eret;
    logic        req;
    logic [31:0] epc_out;

    int checks   = 0;
    int failures = 0;

    string       tagQueue[$];
    logic [31:0] expQueue[$];

    cp0_irq_ctrl #(
        .NUM_HWINT (5),
        .TIMER_EN  (1'b1),
        .PRID      (32'h0000_0001)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .vpc         (vpc),
        .bd_in       (bd_in),
        .exc_code_in (exc_code_in),
        .hwint       (hwint),
        .eret        (eret),
        .req         (req),
        .epc_out     (epc_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic queueExpect(input string tag, input logic [31:0] v);
        tagQueue.push_back(tag);
        expQueue.push_back(v);
    endtask

    task automatic popCompare(input logic [31:0] obs);
        if (expQueue.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_empty: got %h expected queued value", obs);
        end else begin
            checkOutput(tagQueue.pop_front(), obs, expQueue.pop_front());
        end
    endtask

    task automatic expectReg(input string tag, input logic [4:0] a, input logic [31:0] v);
        queueExpect(tag, v);
        addr = a;
        #1;
        popCompare(rdata);
    endtask

    task automatic expectReq(input string tag, input logic v);
        queueExpect(tag, {31'b0, v});
        #1;
        popCompare({31'b0, req});
    endtask

    task automatic expectEpcOut(input string tag, input logic [31:0] v);
        queueExpect(tag, v);
        #1;
        popCompare(epc_out);
    endtask

    task automatic applyStimulus(input logic w, input logic [4:0] a, input logic [31:0] d,
                                 input logic [4:0] exc, input logic [31:0] pc, input logic bd);
        we          = w;
        addr        = a;
        wdata       = d;
        exc_code_in = exc;
        vpc         = pc;
        bd_in       = bd;
    endtask

    // Advance one clock and return idle M-stage inputs (hwint is left alone).
    task automatic cycle();
        @(posedge clk);
        #2;
        we          = 1'b0;
        eret        = 1'b0;
        exc_code_in = 5'd0;
        bd_in       = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        we = 1'b0; addr = '0; wdata = '0; vpc = '0; bd_in = 1'b0;
        exc_code_in = '0; hwint = '0; eret = 1'b0;
        #17;
        reset = 1'b0;

        expectReg("rst_sr", REG_SR, 32'h0);
        expectReg("rst_cause", REG_CAUSE, 32'h0);
        expectReg("rst_epc", REG_EPC, 32'h0);
        expectReg("rst_count", REG_COUNT, 32'h0);
        expectReg("rst_compare", REG_COMPARE, 32'hFFFF_FFFF);
        expectEpcOut("rst_epc_out", 32'h0);
        expectReq("rst_req", 1'b0);
        cycle();
        expectReg("prid", REG_PRID, 32'h0000_0001);
        expectReg("unmapped", 5'd3, 32'h0);

        applyStimulus(1'b1, REG_SR, 32'hFFFF_FFFF, 5'd0, 32'h0, 1'b0);
        expectReg("sr_no_bypass", REG_SR, 32'h0);
        cycle();
        expectReg("sr_writable", REG_SR, 32'h0000_FF03);

        applyStimulus(1'b1, REG_SR, 32'h0, 5'd0, 32'h0, 1'b0);
        cycle();
        applyStimulus(1'b0, REG_SR, 32'h0, EXC_OV, 32'h0000_3010, 1'b0);
        expectReq("exc_req", 1'b1);
        cycle();
        expectReg("exc_cause", REG_CAUSE, 32'h0000_0030);
        expectReg("exc_epc", REG_EPC, 32'h0000_3010);
        expectReg("exc_exl", REG_SR, 32'h0000_0002);
        applyStimulus(1'b0, REG_SR, 32'h0, EXC_RI, 32'h0000_3014, 1'b0);
        expectReq("exc_masked", 1'b0);
        cycle();
        expectReg("masked_cause", REG_CAUSE, 32'h0000_0030);
        expectReg("masked_epc", REG_EPC, 32'h0000_3010);

        applyStimulus(1'b1, REG_SR, 32'h0, 5'd0, 32'h0, 1'b0);
        cycle();
        applyStimulus(1'b1, REG_EPC, 32'h0000_1234, EXC_SYSCALL, 32'h0000_3024, 1'b1);
        expectReq("bd_req", 1'b1);
        cycle();
        expectReg("bd_epc", REG_EPC, 32'h0000_3020);
        expectReg("bd_cause", REG_CAUSE, 32'h8000_0020);

        applyStimulus(1'b1, REG_SR, 32'h0000_0401, 5'd0, 32'h0, 1'b0);
        cycle();
        hwint = 5'b00001;
        expectReq("irq_latency", 1'b0);
        cycle();
        expectReq("irq_req", 1'b1);
        applyStimulus(1'b0, REG_SR, 32'h0, EXC_ADEL, 32'h0000_4000, 1'b0);
        expectReq("irq_with_exc", 1'b1);
        cycle();
        expectReg("irq_cause", REG_CAUSE, 32'h0000_0400);
        expectReg("irq_sr", REG_SR, 32'h0000_0403);
        expectEpcOut("irq_epc_out", 32'h0000_4000);
        hwint = 5'b00000;
        eret  = 1'b1;
        cycle();
        expectReg("eret_sr", REG_SR, 32'h0000_0401);
        expectEpcOut("eret_target", 32'h0000_4000);
        expectReq("eret_req", 1'b0);
        eret = 1'b1;
        cycle();
        expectReg("eret_idle_sr", REG_SR, 32'h0000_0401);

        applyStimulus(1'b1, REG_COUNT, 32'h0, 5'd0, 32'h0, 1'b0);
        cycle();
        applyStimulus(1'b1, REG_COMPARE, 32'h5, 5'd0, 32'h0, 1'b0);
        cycle();
        repeat (4) cycle();
        expectReg("tmr_count5", REG_COUNT, 32'h5);
        expectReg("tmr_not_yet", REG_CAUSE, 32'h0);
        cycle();
        expectReg("tmr_pend", REG_CAUSE, 32'h0000_8000);
        expectReq("tmr_masked", 1'b0);
        applyStimulus(1'b1, REG_COMPARE, 32'h5, 5'd0, 32'h0, 1'b0);
        cycle();
        expectReg("tmr_clear", REG_CAUSE, 32'h0);
        applyStimulus(1'b1, REG_COUNT, 32'hFFFF_FFFF, 5'd0, 32'h0, 1'b0);
        cycle();
        expectReg("tmr_max", REG_COUNT, 32'hFFFF_FFFF);
        cycle();
        expectReg("tmr_wrap", REG_COUNT, 32'h0);

        applyStimulus(1'b0, REG_SR, 32'h0, EXC_OV, 32'h0000_5000, 1'b0);
        expectReq("pre_rst_req", 1'b1);
        cycle();
        expectReg("pre_rst_sr", REG_SR, 32'h0000_0403);
        #1;
        reset = 1'b1;
        #1;
        expectReg("arst_sr", REG_SR, 32'h0);
        expectReg("arst_epc", REG_EPC, 32'h0);
        expectReg("arst_compare", REG_COMPARE, 32'hFFFF_FFFF);
        expectEpcOut("arst_epc_out", 32'h0);
        expectReq("arst_req", 1'b0);
        @(negedge clk);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cp0_irq_ctrl.md
# cp0_irq_ctrl

Parametrised coprocessor-0 for the pipelined MIPS core. It holds SR, Cause, EPC, PRId and an optional Count/Compare timer, and accepts synchronous exceptions plus up to five external hardware interrupt lines. It decides each cycle whether the pipeline must be redirected to the handler. It sits beside the M stage: `mtc0`/`mfc0` access it by register number, the M-stage exception code and victim PC feed it, and `req` drives the pipeline flush.

## Interface
- `NUM_HWINT`, 5, number of external interrupt lines (1..5), mapped to Cause.IP[10 +: NUM_HWINT]
- `TIMER_EN`, 1, instantiate Count/Compare timer on IP[15]; 0 ties IP[15] and reads of Count/Compare to 0
- `PRID`, 32'h0000_0001, constant returned by register 15
- `clk` in 1: clock; all state updates on rising edge
- `reset` in 1: asynchronous, active-high reset
- `we` in 1: `mtc0` write enable
- `addr` in 5: CP0 register number for read and write
- `wdata` in 32: `mtc0` data
- `rdata` out 32: combinational read of `addr`; unmapped numbers read 0
- `vpc` in 32: PC of the M-stage instruction
- `bd_in` in 1: M-stage instruction sits in a delay slot
- `exc_code_in` in 5: M-stage exception code; 0 = none
- `hwint` in NUM_HWINT: level-sensitive external interrupts
- `eret` in 1: M-stage `eret`
- `req` out 1: take exception/interrupt this cycle
- `epc_out` out 32: current EPC, used as the `eret` target

## Operation
- **SR (12).** Writable bits: IM[15:8], EXL[1], IE[0]. All other bits read 0.
- **Cause (13).** Software read-only. BD[31]; IP[15:8] = {timer_pend, 0.., hwint}; ExcCode[6:2]; all other bits 0.
- **EPC (14)** is fully writable. **PRId (15)** is constant. **Count (9)** and **Compare (11)** exist only when TIMER_EN = 1.
- `int_pend = IE & |(IP & IM)`, using the registered IP.
- `req = !EXL & (int_pend | exc_code_in != 0)`. This is combinational.
- Interrupt has priority over a simultaneous exception; the recorded ExcCode is then 0.
- **On `req` at the clock edge:**
  - EXL <= 1
  - BD <= bd_in
  - ExcCode <= int_pend ? 0 : exc_code_in
  - EPC <= bd_in ? vpc - 4 : vpc (32-bit wrap)
- **Write priority per register bit:** `req` > `eret` > `mtc0`. A `mtc0` coinciding with `req` is discarded, because that instruction is flushed.
- **On `eret`** (no `req`): EXL <= 0.
- **IP update.** IP[14:10] <= zero-extended `hwint` every cycle (1-cycle sampling latency). IP[9:8] and unused IP bits are always 0.
- **Timer** (sub-module):
  - Count += 1 every cycle, wrapping 32'hFFFF_FFFF -> 0.
  - A `mtc0` to Count loads `wdata` and suppresses the increment that cycle.
  - timer_pend is set on the edge after Count == Compare.
  - A `mtc0` to Compare clears timer_pend and loads Compare; clear wins over a same-cycle match.
  - Otherwise timer_pend holds.

## Timing
- **Reset values:**
  - SR, Cause, EPC, Count, timer_pend = 0
  - Compare = 32'hFFFF_FFFF, so no spurious match after reset
  - `rdata` = reset value of the addressed register
  - `epc_out` = 0
  - `req` = 0 while `exc_code_in` = 0
- `hwint` rising at edge N sets IP at edge N+1. `req` is then asserted in cycle N+1 if IE = 1, the IM bit is set and EXL = 0.
- `mfc0` in the same cycle as a `mtc0` to the same register returns the old value; there is no bypass.
- After `req`, further exceptions and interrupts are masked until EXL clears via `eret` or `mtc0`.
- `eret` with EXL = 0 is legal; EXL stays 0.
- Reset mid-operation (e.g. timer_pend = 1, EXL = 1) returns every register to its reset value immediately, independent of `clk`.

## Structure
- **Package `cp0_pkg`:**
  - register numbers: COUNT = 9, COMPARE = 11, SR = 12, CAUSE = 13, EPC = 14, PRID = 15
  - bit positions: EXL, IE, BD, IM/IP ranges, ExcCode range
  - ExcCode constants: INT = 0, ADEL = 4, ADES = 5, SYSCALL = 8, RI = 10, OV = 12
- **Sub-module `cp0_timer`** (Count, Compare, timer_pend, with `we`/`addr` decode for registers 9/11). It is instantiated under a `TIMER_EN` generate.

## Test plan
- **Reset and read-back.** After reset, `mtc0` SR = 32'hFFFF_FFFF, then `mfc0` SR -> reads 32'h0000_FF03. Read Compare -> 32'hFFFF_FFFF. Read PRId -> PRID.
- **Exception.** `exc_code_in` = 12, vpc = 32'h3010, bd_in = 0 -> `req` = 1 the same cycle. Then Cause[6:2] = 12, EPC = 32'h3010, EXL = 1. A second `exc_code_in` = 10 on the next cycle -> `req` = 0 and registers unchanged.
- **Delay slot and priority.** bd_in = 1, vpc = 32'h3024, `exc_code_in` = 8, with a concurrent `mtc0` EPC = 32'h1234 -> EPC = 32'h3020, BD = 1, and the write is discarded.
- **Interrupt priority.** SR = 32'h0000_0401, `hwint`[0] = 1 at edge N -> `req` = 1 in cycle N+1. With a simultaneous `exc_code_in` = 4, ExcCode = 0. Then `eret` -> EXL = 0 and `epc_out` = the captured vpc.
- **Timer.** Write Compare = 5, Count = 0 -> timer_pend sets on the edge after Count = 5, and IP[15] = 1. Write Compare = 5 -> timer_pend clears. Count wraps 32'hFFFF_FFFF -> 0.
- **Async reset.** Assert `reset` between clock edges while EXL = 1 -> SR/EPC go to 0 immediately, and `req` = 0 with `exc_code_in` = 0.
